mem_arb_2x8x32: RTL and testbench
=================================

MEM_ARB_2X8X32 -- requirements
Module: mem_arb_2x8x32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters (name, default, meaning) SHALL be: ADDR_W, 3, memory address width; DATA_W, 32, memory data width.
REQ-003 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- reqN  in  1  requester N (N=0,1) access request
- weN  in  1  1=write, 0=read
- addrN  in  ADDR_W  access address
- wdataN  in  DATA_W  write data
- gntN  out  1  one-cycle pulse: request accepted
- rvalidN  out  1  one-cycle pulse: rdataN valid
- rdataN  out  DATA_W  read result, held until next read completes
- mem_address  out  ADDR_W  to memory address
- mem_write_enable  out  1  to memory, 1=write, 0=read
- mem_write_data  out  DATA_W  to memory write data
- mem_read_data  in  DATA_W  from memory; valid one cycle after a read-address edge

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and RDATA.
REQ-005 In IDLE with any reqN high, the block SHALL arbitrate per REQ-012 and register winner, we, addr and wdata into a command register, then enter ACCESS next cycle.
REQ-006 In ACCESS, the block SHALL pulse gnt of the winner for exactly one cycle.
REQ-007 In ACCESS, mem_write_enable SHALL equal the registered we.
REQ-008 On a write, ACCESS SHALL return to IDLE; a write completes in 2 cycles from the IDLE sample.
REQ-009 On a read, ACCESS SHALL go to RDATA.
REQ-010 At the end of RDATA, the block SHALL capture mem_read_data into the winner's rdata register and pulse that rvalid for one cycle, concurrent with the following IDLE.
REQ-011 mem_address and mem_write_data SHALL be driven from the command register in all states; mem_write_enable SHALL be 0 outside ACCESS. Consequence: the memory's registered read address always equals the command address.
REQ-012 Arbitration:
- A single request wins outright.
- On simultaneous requests, the winner is chosen per REQ-020.
- The loser remains pending and is serviced on the next IDLE visit.
REQ-013 Requesters SHALL hold reqN, weN, addrN and wdataN stable until gntN, then drop reqN or present a new request the cycle after gntN; the block SHALL ignore requests outside IDLE.
REQ-014 After IDLE->ACCESS, a new request SHALL be sampled no earlier than the next IDLE cycle; there is no back-to-back issue.
REQ-015 The non-winner's rdata and rvalid SHALL be unaffected by a grant to the other requester.
REQ-016 Address wrap needs no special handling; addr 7 is a legal location and the block SHALL NOT increment addresses.

Reset
REQ-017 While reset_n=0, the block SHALL asynchronously force:
- state=IDLE
- gnt0, gnt1, rvalid0, rvalid1 = 0
- rdata0, rdata1 = 0
- mem_write_enable=0, mem_address=0, mem_write_data=0
- round-robin pointer favouring requester 0
REQ-018 Reset asserted during ACCESS or RDATA SHALL abort the access with no gnt or rvalid pulse; a write in ACCESS whose edge has not occurred SHALL NOT be performed.
REQ-019 After release, the first sampled edge SHALL behave as IDLE.

Configuration
REQ-020 Macro MEM_ARB_RR_EN SHALL select the arbitration policy:
- Defined: round-robin; a one-bit pointer flips to favour the non-winner after every grant; reset favours 0.
- Undefined: fixed priority, requester 0 always wins; no pointer register.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- req0 write addr=3 wdata=32'hDEADBEEF -> gnt0 pulse 1 cycle after sample, mem_write_enable=1 that cycle only; req0 read addr=3 -> rvalid0 pulse 3 cycles after sample, rdata0=32'hDEADBEEF.
- req0 and req1 both read (addrs 1, 2) in the same cycle -> with MEM_ARB_RR_EN: 0 served first then 1; a second simultaneous pair is served 1 first. Without the macro: 0 first both times.
- Write all 8 addrs (0..7, data=addr*32'h11111111) via req1, read back via req0 -> every rdata0 matches, addr 7 correct, rdata1 unchanged.
- reset_n low mid-ACCESS of a write to addr 5 (data 32'hA5A5A5A5) -> no gnt, mem_write_enable drops immediately, later read of addr 5 does not return 32'hA5A5A5A5 (prior value 0 preloaded).
- Continuous req0 with a single req1 held, MEM_ARB_RR_EN defined -> req1 granted within 2 grants; undefined -> req1 starves while req0 is held high.

Source files
------------

// File: rtl/mem_arb_2x8x32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_2x8x32 : two-requester arbiter onto a single-port memory        |
// | Optional: define MEM_ARB_RR_EN for round-robin, else fixed priority 0.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arb_2x8x32 #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                w_sel;

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Contention goes to the pointer; a lone request wins outright.
  assign w_sel = (req0 && req1) ? ptr_q : req1;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && (req0 || req1)) begin
      ptr_d = ~w_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign w_sel = ~req0 & req1;
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = w_sel;
          we_d    = w_sel ? we1    : we0;
          addr_d  = w_sel ? addr1  : addr0;
          wdata_d = w_sel ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = we_q ? IDLE : RDATA;
      RDATA: begin
        // Memory output is valid here because its address was registered at the ACCESS edge.
        if (win_q) begin
          rdata1_d  = mem_read_data;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_read_data;
          rvalid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign gnt0             = (state_q == ACCESS) && !win_q;
  assign gnt1             = (state_q == ACCESS) &&  win_q;
  assign mem_write_enable = (state_q == ACCESS) &&  we_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign rvalid0          = rvalid0_q;
  assign rvalid1          = rvalid1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_2x8x32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arb_2x8x32 : directed self-checking bench for mem_arb_2x8x32     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_arb_2x8x32;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [2:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_write_enable;
  logic [31:0] rdata0, rdata1, mem_write_data;
  logic [31:0] mem_read_data;
  logic [2:0]  mem_address;
  logic        mem_clr = 1'b1;
  logic [31:0] mem [8];
  int          total = 0;
  int          bad = 0;

  mem_arb_2x8x32 #(.ADDR_W(3), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Single-port memory with a registered read address.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (mem_write_enable) begin
      mem[mem_address] <= mem_write_data;
    end
    mem_read_data <= mem[mem_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Issues one request, waits for its grant (and read data); returns in IDLE.
  task automatic issue(input bit port, input bit we, input logic [2:0] a,
                       input logic [31:0] d, output int glat, output logic [31:0] rd);
    glat = 99;
    rd   = 32'hxxxxxxxx;
    if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (port ? gnt1 : gnt0) begin glat = i; break; end
    end
    if (port) req1 = 0; else req0 = 0;
    if (glat != 99) begin
      if (we) tick();
      else begin
        for (int i = 1; i <= 8; i++) begin
          tick();
          if (port ? rvalid1 : rvalid0) begin rd = port ? rdata1 : rdata0; break; end
        end
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin bad++;
      $display("FAIL reset_pulses got=%b want=0000", {gnt0, gnt1, rvalid0, rvalid1}); end
    total++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin bad++;
      $display("FAIL reset_rdata got=%h/%h want=0/0", rdata0, rdata1); end
    total++; if (mem_write_enable !== 1'b0 || mem_address !== 3'd0 || mem_write_data !== 32'h0) begin bad++;
      $display("FAIL reset_mem got we=%b a=%h d=%h want 0", mem_write_enable, mem_address, mem_write_data); end
    reset_n = 1'b1;
    mem_clr = 1'b0;
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 3'd3; wdata0 = 32'hDEADBEEF;
    tick();
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++;
      $display("FAIL wr_gnt got=%b%b want=10", gnt0, gnt1); end
    total++; if (mem_write_enable !== 1'b1 || mem_address !== 3'd3 || mem_write_data !== 32'hDEADBEEF) begin bad++;
      $display("FAIL wr_bus got we=%b a=%h d=%h want 1/3/deadbeef", mem_write_enable, mem_address, mem_write_data); end
    req0 = 0;
    tick();
    total++; if (gnt0 !== 1'b0 || mem_write_enable !== 1'b0) begin bad++;
      $display("FAIL wr_end got gnt0=%b we=%b want 0/0", gnt0, mem_write_enable); end
    req0 = 1; we0 = 0; addr0 = 3'd3;
    tick();
    total++; if (gnt0 !== 1'b1 || mem_write_enable !== 1'b0) begin bad++;
      $display("FAIL rd_gnt got gnt0=%b we=%b want 1/0", gnt0, mem_write_enable); end
    req0 = 0;
    tick();
    total++; if (rvalid0 !== 1'b0 || gnt0 !== 1'b0) begin bad++;
      $display("FAIL rd_early got rvalid0=%b gnt0=%b want 0/0", rvalid0, gnt0); end
    tick();
    total++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin bad++;
      $display("FAIL rd_data got rvalid0=%b rdata0=%h want 1/deadbeef", rvalid0, rdata0); end
    tick();
    total++; if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin bad++;
      $display("FAIL rd_hold got rvalid0=%b rdata0=%h want 0/deadbeef", rvalid0, rdata0); end
  endtask

  task automatic test_simultaneous();
    int g; logic [31:0] rd; bit w2;
    issue(0, 1, 3'd1, 32'h000000A1, g, rd);
    issue(0, 1, 3'd2, 32'h000000B2, g, rd);
    do_reset();
    w2 = RR;
    req0 = 1; we0 = 0; addr0 = 3'd1;
    req1 = 1; we1 = 0; addr1 = 3'd2;
    tick();
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++;
      $display("FAIL sim_first got=%b%b want=10", gnt0, gnt1); end
    tick();
    tick();
    total++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h000000A1 || rvalid1 !== 1'b0) begin bad++;
      $display("FAIL sim_rd0 got rv0=%b rd0=%h rv1=%b want 1/a1/0", rvalid0, rdata0, rvalid1); end
    tick();
    total++; if (gnt0 !== !w2 || gnt1 !== w2) begin bad++;
      $display("FAIL sim_second got=%b%b want=%b%b", gnt0, gnt1, !w2, w2); end
    if (w2) req1 = 0; else req0 = 0;
    tick();
    tick();
    total++; if ((w2 ? rdata1 : rdata0) !== (w2 ? 32'h000000B2 : 32'h000000A1) || (w2 ? rvalid1 : rvalid0) !== 1'b1) begin bad++;
      $display("FAIL sim_rd2 got rdata=%h", w2 ? rdata1 : rdata0); end
    tick();
    total++; if (gnt0 !== w2 || gnt1 !== !w2) begin bad++;
      $display("FAIL sim_third got=%b%b want=%b%b", gnt0, gnt1, w2, !w2); end
    req0 = 0; req1 = 0;
    tick();
    tick();
    total++; if (rdata0 !== 32'h000000A1 || rdata1 !== 32'h000000B2) begin bad++;
      $display("FAIL sim_final got rd0=%h rd1=%h want a1/b2", rdata0, rdata1); end
  endtask

  task automatic test_all_addrs();
    int g; logic [31:0] rd; logic [31:0] exp;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      exp = a * 32'h11111111;
      issue(1, 1, a[2:0], exp, g, rd);
      total++; if (g != 1) begin bad++;
        $display("FAIL fill_gnt addr=%0d got lat=%0d want 1", a, g); end
    end
    for (int a = 0; a < 8; a++) begin
      exp = a * 32'h11111111;
      issue(0, 0, a[2:0], 32'h0, g, rd);
      total++; if (rd !== exp) begin bad++;
        $display("FAIL readback addr=%0d got=%h want=%h", a, rd, exp); end
    end
    total++; if (rdata1 !== 32'h0 || rvalid1 !== 1'b0) begin bad++;
      $display("FAIL rdata1_untouched got=%h rv=%b want 0/0", rdata1, rvalid1); end
  endtask

  task automatic test_reset_abort();
    int g; logic [31:0] rd;
    mem_clr = 1'b1;
    do_reset();
    mem_clr = 1'b0;
    req0 = 1; we0 = 1; addr0 = 3'd5; wdata0 = 32'hA5A5A5A5;
    tick();
    total++; if (mem_write_enable !== 1'b1 || gnt0 !== 1'b1) begin bad++;
      $display("FAIL abort_pre got we=%b gnt0=%b want 1/1", mem_write_enable, gnt0); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (gnt0 !== 1'b0 || mem_write_enable !== 1'b0 || mem_address !== 3'd0) begin bad++;
      $display("FAIL abort_async got gnt0=%b we=%b a=%h want 0/0/0", gnt0, mem_write_enable, mem_address); end
    req0 = 0;
    tick();
    reset_n = 1'b1;
    issue(0, 0, 3'd5, 32'h0, g, rd);
    total++; if (g != 1 || rd !== 32'h0) begin bad++;
      $display("FAIL abort_read got lat=%0d data=%h want 1/00000000", g, rd); end
  endtask

  task automatic test_starve();
    int ngr, first1, to;
    do_reset();
    ngr = 0; first1 = 0;
    req1 = 1; we1 = 1; addr1 = 3'd6; wdata1 = 32'h66666666;
    req0 = 1; we0 = 1; addr0 = 3'd0; wdata0 = 32'h0;
    for (int i = 0; i < 30 && ngr < 6; i++) begin
      tick();
      if (gnt0) ngr++;
      if (gnt1) begin ngr++; if (first1 == 0) first1 = ngr; req1 = 0; end
    end
    req0 = 0;
    total++; if (ngr != 6) begin bad++;
      $display("FAIL starve_grants got=%0d want=6", ngr); end
    total++; if (first1 != (RR ? 2 : 0)) begin bad++;
      $display("FAIL starve_first1 got=%0d want=%0d", first1, RR ? 2 : 0); end
    to = 1;
    if (req1) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        if (gnt1) begin to = 0; req1 = 0; break; end
      end
      total++; if (to != 0) begin bad++;
        $display("FAIL starve_release got no gnt1 want gnt1"); end
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_all_addrs();
    test_reset_abort();
    test_starve();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
